// File: rtl/pulse_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : pulse_timer_bank
// Description : NUM_CH independent programmable period/width pulse generators
//               (periodic or one-shot, start/stop). Optional toggle outputs
//               are built when PULSE_TIMER_TOGGLE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_timer_bank #(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 150000000,
  parameter int unsigned DEFAULT_WIDTH  = 1,
  localparam int         c_CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [c_CH_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic              cfg_oneshot,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic [NUM_CH-1:0] pulse,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] toggle
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  // Assertion is immediate; release is delayed by two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [CNT_W-1:0] r_p, w_p_nx, r_w, w_w_nx;
    logic             r_m, w_m_nx;
    logic             r_pulse, w_pulse_nx;
    logic [CNT_W-1:0] r_period_s, r_width_s;
    logic             r_oneshot_s;
    logic             w_wr, w_wrap, w_hit, w_ld_m;
    logic [CNT_W-1:0] w_raw_p, w_ld_p, w_ld_w;

    assign w_wr    = cfg_we && (cfg_ch == c_CH_W'(i));
    // Same-cycle write bypasses the shadow so a coincident load sees it.
    assign w_raw_p = w_wr ? cfg_period : r_period_s;
    assign w_ld_p  = (w_raw_p < CNT_W'(2)) ? CNT_W'(2) : w_raw_p;
    assign w_ld_w  = w_wr ? cfg_width : r_width_s;
    assign w_ld_m  = w_wr ? cfg_oneshot : r_oneshot_s;
    assign w_wrap  = (r_cnt == r_p - CNT_W'(1));
    // cnt >= P-W rearranged as cnt+W >= P to stay unsigned without wrap.
    assign w_hit   = ({1'b0, r_cnt} + {1'b0, r_w}) >= {1'b0, r_p};

    always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_period_s  <= CNT_W'(DEFAULT_PERIOD);
        r_width_s   <= CNT_W'(DEFAULT_WIDTH);
        r_oneshot_s <= 1'b0;
      end else if (w_wr) begin
        r_period_s  <= cfg_period;
        r_width_s   <= cfg_width;
        r_oneshot_s <= cfg_oneshot;
      end
    end

    always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_p_nx     = r_p;
      w_w_nx     = r_w;
      w_m_nx     = r_m;
      w_pulse_nx = (r_state == RUN) && w_hit;
      if (stop[i]) begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
        w_pulse_nx = 1'b0;
      end else if (start[i]) begin
        w_state_nx = RUN;
        w_cnt_nx   = '0;
        w_p_nx     = w_ld_p;
        w_w_nx     = w_ld_w;
        w_m_nx     = w_ld_m;
      end else if (r_state == RUN) begin
        if (w_wrap) begin
          w_cnt_nx = '0;
          if (r_m) begin
            w_state_nx = IDLE;
          end else begin
            w_p_nx = w_ld_p;
            w_w_nx = w_ld_w;
            w_m_nx = w_ld_m;
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_p     <= CNT_W'(2);
        r_w     <= '0;
        r_m     <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_state <= w_state_nx;
        r_cnt   <= w_cnt_nx;
        r_p     <= w_p_nx;
        r_w     <= w_w_nx;
        r_m     <= w_m_nx;
        r_pulse <= w_pulse_nx;
      end
    end

    assign pulse[i] = r_pulse;
    assign busy[i]  = (r_state == RUN);

`ifdef PULSE_TIMER_TOGGLE_EN
    logic r_tgl;

    always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n)                                        r_tgl <= 1'b0;
      else if (stop[i])                                    r_tgl <= 1'b0;
      else if (!start[i] && (r_state == RUN) && w_wrap)    r_tgl <= ~r_tgl;
    end

    assign toggle[i] = r_tgl;
`else
    assign toggle[i] = 1'b0;
`endif
  end

endmodule
`default_nettype wire
